// File: rtl/eeg_feat_pkg.sv
// Shared constants and FSM state type for the EEG feature-extraction stages.
package eeg_feat_pkg;

  localparam int unsigned DATA_W  = 16;
  localparam int unsigned WIN_LEN = 250;
  localparam int unsigned PTR_W   = 8;
  localparam int unsigned DIFF_W  = 16;
  localparam int unsigned SUM_W   = 25;

  typedef enum logic [1:0] {
    PRIME = 2'd0,
    FILL  = 2'd1,
    RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/ll_delay_line.sv
// Circular buffer of |difference| values: combinational read, synchronous write.
// A read and a write to the same address in one cycle returns the old entry.
module ll_delay_line #(
  parameter int unsigned DIFF_W  = 16,
  parameter int unsigned WIN_LEN = 250,
  parameter int unsigned PTR_W   = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [PTR_W-1:0]  wr_addr_i,
  input  logic [DIFF_W-1:0] wr_data_i,
  input  logic [PTR_W-1:0]  rd_addr_i,
  output logic [DIFF_W-1:0] rd_data_c_o
);

  // Storage is intentionally not reset; the owner masks stale entries by state.
  logic [DIFF_W-1:0] mem_q [WIN_LEN];

  // Write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_c_o = mem_q[rd_addr_i];

endmodule

// File: rtl/line_length.sv
// Line-length feature: running sum of |x[n]-x[n-1]| over a sliding WIN_LEN window.
module line_length #(
  parameter int unsigned DATA_W  = eeg_feat_pkg::DATA_W,
  parameter int unsigned WIN_LEN = eeg_feat_pkg::WIN_LEN,
  parameter int unsigned PTR_W   = eeg_feat_pkg::PTR_W,
  parameter int unsigned DIFF_W  = eeg_feat_pkg::DIFF_W,
  parameter int unsigned SUM_W   = eeg_feat_pkg::SUM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [SUM_W-1:0]  dout,
  output logic              dout_valid,
  output logic              win_full
);

  import eeg_feat_pkg::*;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  prev_q, prev_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   fill_cnt_q, fill_cnt_d;
  logic [SUM_W-1:0]   sum_q, sum_d;
  logic [SUM_W-1:0]   dout_q, dout_d;
  logic               dout_valid_q, dout_valid_d;
  logic               win_full_q, win_full_d;

  logic                accept_c;
  logic                we_c;
  logic signed [DATA_W:0] diff_c;
  logic signed [DATA_W:0] mag_c;
  logic [DIFF_W-1:0]   d_c;
  logic [DIFF_W-1:0]   old_c;
  logic [DIFF_W-1:0]   sub_c;
  logic [SUM_W-1:0]    sum_upd_c;
  logic [PTR_W-1:0]    ptr_inc_c;

  // en is active-low: a sample is taken only when strobed and enabled.
  assign accept_c = din_valid & ~en;

  // Absolute difference formed one bit wider than the samples so it cannot overflow.
  assign diff_c = $signed({din[DATA_W-1], din}) - $signed({prev_q[DATA_W-1], prev_q});
  assign mag_c  = diff_c[DATA_W] ? -diff_c : diff_c;
  assign d_c    = DIFF_W'($unsigned(mag_c));

  // Single add/subtract: the evicted entry is only subtracted once the window is full.
  assign sub_c     = (state_q == RUN) ? old_c : '0;
  assign sum_upd_c = sum_q + SUM_W'(d_c) - SUM_W'(sub_c);

  // Explicit wrap so WIN_LEN need not be a power of two.
  assign ptr_inc_c = (wr_ptr_q == PTR_W'(WIN_LEN - 1)) ? '0 : wr_ptr_q + PTR_W'(1);

  ll_delay_line #(
    .DIFF_W  (DIFF_W),
    .WIN_LEN (WIN_LEN),
    .PTR_W   (PTR_W)
  ) u_line (
    .clk         (clk),
    .we_i        (we_c),
    .wr_addr_i   (wr_ptr_q),
    .wr_data_i   (d_c),
    .rd_addr_i   (wr_ptr_q),
    .rd_data_c_o (old_c)
  );

  // Next-state and datapath control; everything holds unless a sample is accepted.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    wr_ptr_d     = wr_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    sum_d        = sum_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    win_full_d   = win_full_q;
    we_c         = 1'b0;
    if (accept_c) begin
      unique case (state_q)
        PRIME: begin
          prev_d  = din;
          state_d = FILL;
        end
        FILL: begin
          prev_d     = din;
          we_c       = 1'b1;
          sum_d      = sum_upd_c;
          wr_ptr_d   = ptr_inc_c;
          fill_cnt_d = fill_cnt_q + PTR_W'(1);
          if (fill_cnt_q == PTR_W'(WIN_LEN - 1)) begin
            state_d      = RUN;
            win_full_d   = 1'b1;
            dout_valid_d = 1'b1;
            dout_d       = sum_upd_c;
          end
        end
        RUN: begin
          prev_d       = din;
          we_c         = 1'b1;
          sum_d        = sum_upd_c;
          wr_ptr_d     = ptr_inc_c;
          dout_valid_d = 1'b1;
          dout_d       = sum_upd_c;
        end
        default: begin
          state_d = PRIME;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= PRIME;
      prev_q       <= '0;
      wr_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      sum_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      win_full_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      wr_ptr_q     <= wr_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      sum_q        <= sum_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      win_full_q   <= win_full_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign win_full   = win_full_q;

endmodule

// File: tb/tb_line_length.sv
// Directed bench for line_length with the default 250-sample window.
module tb_line_length;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] din;
  logic        din_valid;
  logic [24:0] dout;
  logic        dout_valid;
  logic        win_full;

  int n_vec;
  int n_bad;

  logic        obs_valid;
  logic [24:0] obs_dout;
  logic        obs_full;

  line_length dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .win_full   (win_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    din_valid = 1'b0;
    en        = 1'b0;
    din       = '0;
    rst       = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // One cycle with a strobed sample; drop=1 holds en high so the sample is ignored.
  task automatic push(input logic [15:0] s, input logic drop);
    @(negedge clk);
    din       = s;
    din_valid = 1'b1;
    en        = drop;
    @(posedge clk);
    #1;
    obs_valid = dout_valid;
    obs_dout  = dout;
    obs_full  = win_full;
    din_valid = 1'b0;
    en        = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
    din_valid = 1'b0;
    en        = 1'($urandom_range(0, 1));
    @(posedge clk);
    #1;
    obs_valid = dout_valid;
    obs_dout  = dout;
    obs_full  = win_full;
    en        = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    din_valid = 1'b0;
    en        = 1'b0;
    din       = '0;
    #12;
    n_vec++;
    if (dout !== 25'd0 || dout_valid !== 1'b0 || win_full !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: dout=%0d valid=%b full=%b, required 0/0/0", dout, dout_valid, win_full);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_constant();
    int pulses;
    logic exp_v;
    pulses = 0;
    for (int i = 1; i <= 300; i++) begin
      push(16'd100, 1'b0);
      exp_v = (i >= 251);
      n_vec++;
      if (obs_valid !== exp_v || obs_full !== exp_v) begin
        n_bad++;
        $display("FAIL const_valid[%0d]: valid=%b full=%b, required %b", i, obs_valid, obs_full, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (obs_dout !== 25'd0) begin
          n_bad++;
          $display("FAIL const_dout[%0d]: got %0d, required 0", i, obs_dout);
        end
      end
      if (obs_valid === 1'b1) pulses++;
    end
    n_vec++;
    if (pulses !== 50) begin
      n_bad++;
      $display("FAIL const_pulses: got %0d, required 50", pulses);
    end
  endtask

  task automatic test_alternating(input int n);
    logic exp_v;
    for (int i = 1; i <= n; i++) begin
      push((i % 2 == 1) ? 16'd1000 : 16'hFC18, 1'b0);
      exp_v = (i >= 251);
      n_vec++;
      if (obs_valid !== exp_v) begin
        n_bad++;
        $display("FAIL alt_valid[%0d]: got %b, required %b", i, obs_valid, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (obs_dout !== 25'd500000) begin
          n_bad++;
          $display("FAIL alt_dout[%0d]: got %0d, required 500000", i, obs_dout);
        end
      end
    end
  endtask

  task automatic test_full_scale();
    for (int i = 1; i <= 260; i++) begin
      push((i % 2 == 1) ? 16'h7FFF : 16'h8000, 1'b0);
      if (i >= 251) begin
        n_vec++;
        if (obs_valid !== 1'b1 || obs_dout !== 25'd16383750 || obs_dout[24] !== 1'b0) begin
          n_bad++;
          $display("FAIL fullscale[%0d]: valid=%b dout=%0d, required 1/16383750", i, obs_valid, obs_dout);
        end
      end
    end
  endtask

  task automatic test_impulse();
    int p;
    int exp_d;
    for (int i = 1; i <= 510; i++) begin
      push((i == 252) ? 16'd10 : 16'd0, 1'b0);
      if (i >= 251) begin
        p = i - 251;
        if (p == 0)        exp_d = 0;
        else if (p == 1)   exp_d = 10;
        else if (p <= 250) exp_d = 20;
        else if (p == 251) exp_d = 10;
        else               exp_d = 0;
        n_vec++;
        if (obs_valid !== 1'b1 || obs_dout !== 25'(exp_d)) begin
          n_bad++;
          $display("FAIL impulse[p=%0d]: valid=%b dout=%0d, required 1/%0d", p, obs_valid, obs_dout, exp_d);
        end
      end
    end
  endtask

  task automatic test_gaps();
    int acc[$];
    int exp_d;
    int a;
    int df;
    logic [24:0] last;
    logic [15:0] s;
    last = 25'd0;
    while (acc.size() < 320) begin
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) begin
        idle();
        n_vec++;
        if (obs_valid !== 1'b0 || obs_dout !== last) begin
          n_bad++;
          $display("FAIL gap_idle: valid=%b dout=%0d, required 0/%0d", obs_valid, obs_dout, last);
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        push(16'd7777, 1'b1);
        n_vec++;
        if (obs_valid !== 1'b0 || obs_dout !== last) begin
          n_bad++;
          $display("FAIL gap_drop: valid=%b dout=%0d, required 0/%0d", obs_valid, obs_dout, last);
        end
      end
      a = (acc.size() % 2 == 0) ? 1000 : -1000;
      s = 16'(a);
      push(s, 1'b0);
      acc.push_back(a);
      n_vec++;
      if (acc.size() >= 251) begin
        exp_d = 0;
        for (int k = acc.size() - 250; k < acc.size(); k++) begin
          df = acc[k] - acc[k-1];
          exp_d += (df < 0) ? -df : df;
        end
        if (obs_valid !== 1'b1 || obs_dout !== 25'(exp_d)) begin
          n_bad++;
          $display("FAIL gap_dout[%0d]: valid=%b dout=%0d, required 1/%0d", acc.size(), obs_valid, obs_dout, exp_d);
        end
        last = 25'(exp_d);
      end else if (obs_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL gap_early[%0d]: valid=%b, required 0", acc.size(), obs_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    test_alternating(260);
    n_vec++;
    if (obs_full !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_rst_full: got %b, required 1", obs_full);
    end
    @(negedge clk);
    din       = 16'd1000;
    din_valid = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if (dout !== 25'd0 || dout_valid !== 1'b0 || win_full !== 1'b0) begin
      n_bad++;
      $display("FAIL async_rst: dout=%0d valid=%b full=%b, required 0/0/0", dout, dout_valid, win_full);
    end
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    test_alternating(260);
  endtask

  initial begin
    n_vec     = 0;
    n_bad     = 0;
    obs_valid = 1'b0;
    obs_dout  = '0;
    obs_full  = 1'b0;
    test_reset();
    apply_reset();
    test_constant();
    apply_reset();
    test_alternating(300);
    apply_reset();
    test_full_scale();
    apply_reset();
    test_impulse();
    apply_reset();
    test_gaps();
    apply_reset();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
